// File: rtl/player_position_if.sv
// Player marker bus: lane-change request in, seven-segment marker pattern out.
// PlayerToggle is a one-cycle request with no back-pressure; PlayerPosition is always valid.
interface player_position_if;
    logic       PlayerToggle;
    logic [6:0] PlayerPosition;

    modport master (output PlayerToggle, input PlayerPosition);
    modport slave  (input PlayerToggle, output PlayerPosition);
endinterface

// File: rtl/player_position.sv
// Two-lane player marker driving a seven-segment digit (segment a = top, d = bottom).
// Define PLAYER_POSITION_EDGE_DETECT_EN to flip once per rising edge of PlayerToggle instead of once per high cycle.
module player_position #(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter bit START_BOTTOM = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    player_position_if.slave  bus,
    output logic              lane
);

    typedef enum logic {
        LANE_TOP    = 1'b0,
        LANE_BOTTOM = 1'b1
    } lane_t;

    localparam lane_t      RESET_LANE = START_BOTTOM ? LANE_BOTTOM : LANE_TOP;
    localparam logic [6:0] SEG_TOP    = ACTIVE_LOW ? 7'b1111110 : 7'b0000001;
    localparam logic [6:0] SEG_BOTTOM = ACTIVE_LOW ? 7'b1110111 : 7'b0001000;

    lane_t      state_q;
    lane_t      state_d;
    logic [6:0] seg_q;
    logic [6:0] seg_d;
    logic       qualified;

`ifdef PLAYER_POSITION_EDGE_DETECT_EN
    logic toggle_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_prev_q <= 1'b0;
        end else begin
            toggle_prev_q <= bus.PlayerToggle;
        end
    end

    assign qualified = bus.PlayerToggle & ~toggle_prev_q;
`else
    assign qualified = bus.PlayerToggle;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_LANE;
            seg_q   <= (RESET_LANE == LANE_BOTTOM) ? SEG_BOTTOM : SEG_TOP;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
        end
    end

    // The segment pattern is registered from the next lane so it updates on the same edge as the lane.
    always_comb begin
        state_d = state_q;
        if (qualified) begin
            state_d = (state_q == LANE_TOP) ? LANE_BOTTOM : LANE_TOP;
        end
        seg_d = (state_d == LANE_BOTTOM) ? SEG_BOTTOM : SEG_TOP;
    end

    assign bus.PlayerPosition = seg_q;
    assign lane               = state_q;

endmodule

// File: tb/tb_player_position.sv
// Directed bench: active-low, active-high and bottom-start instances share one stimulus stream.
module tb_player_position;

    localparam logic [6:0] TOP_L = 7'b1111110;
    localparam logic [6:0] BOT_L = 7'b1110111;
    localparam logic [6:0] TOP_H = 7'b0000001;
    localparam logic [6:0] BOT_H = 7'b0001000;

    logic clk;
    logic rst;
    logic tog;
    logic lane_a;
    logic lane_b;
    logic lane_c;
    int   checks;
    int   errors;
    logic exp_lane;

    player_position_if bus_a ();
    player_position_if bus_b ();
    player_position_if bus_c ();

    assign bus_a.PlayerToggle = tog;
    assign bus_b.PlayerToggle = tog;
    assign bus_c.PlayerToggle = tog;

    player_position #(.ACTIVE_LOW(1'b1), .START_BOTTOM(1'b0)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .lane(lane_a));
    player_position #(.ACTIVE_LOW(1'b0), .START_BOTTOM(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .lane(lane_b));
    player_position #(.ACTIVE_LOW(1'b1), .START_BOTTOM(1'b1)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c.slave), .lane(lane_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Bottom-start instance always sits in the opposite lane to the others.
    task automatic check_all(input string tag);
        check({tag, "_al"}, bus_a.PlayerPosition, exp_lane ? BOT_L : TOP_L);
        check({tag, "_ah"}, bus_b.PlayerPosition, exp_lane ? BOT_H : TOP_H);
        check({tag, "_sb"}, bus_c.PlayerPosition, exp_lane ? TOP_L : BOT_L);
        check({tag, "_lane"}, {6'd0, lane_a}, {6'd0, exp_lane});
        check({tag, "_lane_sb"}, {6'd0, lane_c}, {6'd0, ~exp_lane});
    endtask

    task automatic pulse(input string tag);
        tog = 1'b1;
        tick();
        tog = 1'b0;
        exp_lane = ~exp_lane;
        check_all(tag);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        tog      = 1'b0;
        exp_lane = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("reset");
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_all("idle_after_reset");
        end

        pulse("first_pulse");
        for (int i = 0; i < 11; i++) begin
            tick();
            check_all("hold_bottom");
        end
        pulse("second_pulse");

        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 11; i++) begin
                tick();
                check_all("gap");
            end
            pulse("train_pulse");
        end
        check("train_end", bus_a.PlayerPosition, TOP_L);

        tog = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef PLAYER_POSITION_EDGE_DETECT_EN
            exp_lane = 1'b1;
`else
            exp_lane = ~exp_lane;
`endif
            check_all("held_level");
        end
        tog = 1'b0;
        tick();
        check_all("after_held_level");
`ifdef PLAYER_POSITION_EDGE_DETECT_EN
        check("held_end", bus_a.PlayerPosition, BOT_L);
`else
        check("held_end", bus_a.PlayerPosition, TOP_L);
        pulse("to_bottom");
`endif

        rst = 1'b1;
        tog = 1'b1;
        tick();
        exp_lane = 1'b0;
        check_all("reset_wins");
        rst = 1'b0;
        tick();
        exp_lane = 1'b1;
        check_all("toggle_through_release");
        tog = 1'b0;
        tick();
        check_all("after_release_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_position.md
PLAYER_POSITION -- requirements
Module: player_position

Interface
REQ-001 Parameter ACTIVE_LOW, default 1, meaning: 1 = segment outputs are active-low (common-anode display); 0 = active-high.
REQ-002 Parameter START_BOTTOM, default 0, meaning: lane loaded by reset (0 = top, 1 = bottom).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 PlayerToggle  input  1  lane-change request, normally a shaped one-cycle pulse, synchronous to clk.
REQ-006 PlayerPosition  output  7  seven-segment pattern of the player marker; bit order [6:0] = g,f,e,d,c,b,a.

Function
REQ-007 The block SHALL hold a one-bit lane state: TOP (segment a lit) or BOTTOM (segment d lit).
REQ-008 PlayerPosition SHALL be driven directly from a register with no combinational path from inputs.
REQ-009 With ACTIVE_LOW=1, the encodings SHALL be TOP = 7'b1111110 and BOTTOM = 7'b1110111.
REQ-010 With ACTIVE_LOW=0, the encodings SHALL be TOP = 7'b0000001 and BOTTOM = 7'b0001000.
REQ-011 The block SHALL never drive any other pattern; exactly one segment is lit in every cycle after the first clock edge.
REQ-012 A qualified toggle (see REQ-018/019) sampled at rising edge N SHALL flip the lane, and the new pattern SHALL appear on PlayerPosition immediately after edge N (one-cycle latency).
REQ-013 Toggling SHALL wrap: TOP->BOTTOM->TOP; there is no saturation.
REQ-014 When PlayerToggle is low, the lane SHALL hold indefinitely.
REQ-015 When rst and PlayerToggle are both high at an edge, reset SHALL win and the toggle SHALL be discarded.

Reset
REQ-016 When rst is high at a rising edge, the lane SHALL load TOP (START_BOTTOM=0) or BOTTOM (START_BOTTOM=1), and PlayerPosition SHALL show the matching pattern after that edge.
REQ-017 Reset SHALL clear the edge-detector history register (REQ-018) to 0; a toggle held high through reset release therefore counts as a new edge on the first edge after release.

Configuration
REQ-018 With macro PLAYER_POSITION_EDGE_DETECT_EN defined, a toggle SHALL qualify only when PlayerToggle is 1 now and was 0 at the previous edge (registered history), so a held level causes exactly one flip.
REQ-019 Without PLAYER_POSITION_EDGE_DETECT_EN, every edge with PlayerToggle high SHALL qualify; a level held K cycles causes K flips.

Verification
REQ-020 Hold rst high 3 cycles with PlayerToggle=0, then release -> PlayerPosition = 7'b1111110 from the first reset edge onward and stable for 6 idle cycles.
REQ-021 After reset, apply a 1-cycle pulse -> 7'b1110111 after that edge; a second pulse 12 cycles later -> 7'b1111110.
REQ-022 Apply 8 one-cycle pulses spaced 12 cycles apart -> pattern alternates after each pulse, ending at 7'b1111110; unchanged during idle gaps.
REQ-023 Hold PlayerToggle high 4 cycles from TOP -> with the macro, exactly one flip (ends 7'b1110111); without the macro, 4 flips (ends 7'b1111110).
REQ-024 Assert rst and PlayerToggle together while in BOTTOM -> 7'b1111110 after the edge; with ACTIVE_LOW=0, repeat REQ-020/021 and expect 7'b0000001 and 7'b0001000.
